sound_fx_sequencer: RTL and testbench
=====================================

// Module: sound_fx_sequencer
// PURPOSE
//  Plays short sound effects (shot, explosion, UFO, ...) as note sequences. On a request it steps
//  through a per-effect note table, driving the divider value and sound-enable consumed by the
//  sound unit's clock-enable prescaler/DAC path. It holds each note for a programmed time and
//  reports completion. Sits between game logic (requests) and the prescaler (tone pitch).
// PARAMETERS
//  CLKS_PER_MS  50000  clk cycles per 1 ms duration tick (50 MHz); sim uses 10
//  GAP_MS       1      silent gap between consecutive notes, ms; 0 = no gap state
//  MAX_STEPS    16     max notes per effect; step index width = $clog2(MAX_STEPS)
// PORTS
//  clk            in   1   system clock
//  resetN         in   1   reset, asynchronous, active-low
//  fx_req         in   1   one-cycle request strobe
//  fx_id          in   3   effect number, sampled when fx_req=1; higher value = higher priority
//  preScaleValue  out  10  divider value for the prescaler (tone pitch)
//  enableSound    out  1   1 while a non-rest note is sounding
//  busy           out  1   1 from accept cycle until done
//  fx_done        out  1   one-cycle pulse when an effect finishes normally
//  cur_id         out  3   effect currently playing (valid while busy)
// BEHAVIOUR
//  Reset: state=IDLE; preScaleValue=0, enableSound=0, busy=0, fx_done=0, cur_id=0, counters=0.
//  All outputs registered. States IDLE, LOAD, PLAY, GAP.
//  IDLE: fx_req=1 -> latch cur_id=fx_id, step=0, busy=1 next cycle, -> LOAD.
//  LOAD (1 cycle): register ROM word {pitch[9:0], dur_ms[7:0], last}; preScaleValue=pitch;
//    enableSound = (pitch!=0) (pitch 0 = rest); dur_ms 0 is treated as 1; clear ms/clk counters; -> PLAY.
//    Sound becomes audible 2 cycles after the accepted fx_req.
//  PLAY: clk counter counts 0..CLKS_PER_MS-1, wraps and increments ms counter; when ms counter
//    reaches dur_ms at the wrap: enableSound=0;
//    if last or step==MAX_STEPS-1 -> IDLE, fx_done=1 for one cycle, busy=0 (same cycle);
//    else step++ and -> GAP (GAP_MS>0) or LOAD (GAP_MS=0).
//  GAP: enableSound=0, preScaleValue held; after GAP_MS ms -> LOAD.
//  Request while busy: fx_id >= cur_id -> restart (preempt): latch new id, step=0, -> LOAD next
//    cycle, no fx_done for the aborted effect; fx_id < cur_id -> ignored.
//  fx_req coincident with the completion cycle: restart wins, fx_done not asserted, busy stays 1.
//  Step index never wraps: MAX_STEPS-1 forces termination even without last flag.
//  Unused effect ids map to a single rest note of 1 ms with last=1.
//  Reset mid-effect: immediate return to reset values, no fx_done.
//  Counter widths: clk counter $clog2(CLKS_PER_MS); ms counter 8 bits (max 255 ms per note).
// STRUCTURE
//  Package sound_pkg: fx_state_t enum (IDLE,LOAD,PLAY,GAP), fx_note_t struct
//    {logic [9:0] pitch; logic [7:0] dur_ms; logic last;}, FX_ID_W=3, effect id constants
//    (FX_SHOT, FX_EXPLODE, FX_UFO, FX_PLAYER_HIT).
//  Sub-module sound_fx_rom: combinational case table (fx_id, step) -> fx_note_t.
//  Top: FSM, ms timebase counters, request arbitration, output registers.
// TESTING (CLKS_PER_MS=10, GAP_MS=1)
//  1. FX_SHOT (3 notes 500/2ms,400/2ms,300/1ms last): fx_req at t0 -> busy@t0+1, enableSound@t0+2,
//     preScaleValue 500 for 20 clks, gap 10 clks, 400, 300, single fx_done, busy low same cycle.
//  2. Rest note (pitch 0, 3ms): enableSound stays 0 for 30 clks, sequence continues after it.
//  3. Preempt: FX_SHOT playing, fx_req fx_id=FX_EXPLODE (higher) -> restart at step 0 of explode,
//     no fx_done for shot; then fx_req FX_SHOT (lower) mid-explode -> ignored, cur_id unchanged.
//  4. fx_req same cycle as completion -> no fx_done, busy never drops, new effect LOAD next cycle.
//  5. Table without last flag -> terminates after step MAX_STEPS-1 with fx_done; unused id ->
//     1 ms rest then fx_done.
//  6. resetN low mid-PLAY -> all outputs 0 asynchronously; after release IDLE, fx_req works normally.

Source files
------------

// File: rtl/sound_fx_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// sound_pkg
// Shared types and constants for the sound-effect sequencer:
//   fx_state_t  - sequencer FSM states
//   fx_note_t   - one note table word {pitch, dur_ms, last}
//   FX_*        - effect numbers; a larger number has higher priority
//   make_note   - builds a note word for the ROM table
// ---------------------------------------------------------------------------
package sound_pkg;

    localparam int FX_ID_W = 3;
    localparam int PITCH_W = 10;
    localparam int DUR_W   = 8;

    localparam logic [FX_ID_W-1:0] FX_SHOT       = 3'd1;
    localparam logic [FX_ID_W-1:0] FX_EXPLODE    = 3'd2;
    localparam logic [FX_ID_W-1:0] FX_UFO        = 3'd3;
    localparam logic [FX_ID_W-1:0] FX_PLAYER_HIT = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PLAY,
        GAP
    } fx_state_t;

    typedef struct packed {
        logic [PITCH_W-1:0] pitch;
        logic [DUR_W-1:0]   dur_ms;
        logic               last;
    } fx_note_t;

    function automatic fx_note_t make_note(input logic [PITCH_W-1:0] pitch,
                                           input logic [DUR_W-1:0]   dur_ms,
                                           input logic               last);
        fx_note_t n;
        n.pitch  = pitch;
        n.dur_ms = dur_ms;
        n.last   = last;
        return n;
    endfunction

endpackage

// File: rtl/sound_fx_sequencer_if.sv
// ---------------------------------------------------------------------------
// sound_fx_sequencer_if
// Request / tone bus between game logic (master) and the effect sequencer
// (slave).
//   fx_req, fx_id               master -> slave   request strobe and effect number
//   preScaleValue, enableSound  slave  -> master  prescaler divider and sound gate
//   busy, fx_done, cur_id       slave  -> master  playback status
// ---------------------------------------------------------------------------
interface sound_fx_sequencer_if;
    import sound_pkg::*;

    logic                fx_req;
    logic [FX_ID_W-1:0]  fx_id;
    logic [PITCH_W-1:0]  preScaleValue;
    logic                enableSound;
    logic                busy;
    logic                fx_done;
    logic [FX_ID_W-1:0]  cur_id;

    modport master (
        output fx_req, fx_id,
        input  preScaleValue, enableSound, busy, fx_done, cur_id
    );

    modport slave (
        input  fx_req, fx_id,
        output preScaleValue, enableSound, busy, fx_done, cur_id
    );

endinterface

// File: rtl/sound_fx_rom.sv
// ---------------------------------------------------------------------------
// sound_fx_rom
// Combinational note table: (fx_id, step) -> fx_note_t.
//   fx_id  in   effect number
//   step   in   note index within the effect
//   note   out  {pitch, dur_ms, last}; pitch 0 is a rest
// Ids without a table play a single 1 ms rest and finish.
// ---------------------------------------------------------------------------
module sound_fx_rom
    import sound_pkg::*;
#(
    parameter int STEP_W = 4
) (
    input  logic [FX_ID_W-1:0] fx_id,
    input  logic [STEP_W-1:0]  step,
    output fx_note_t           note
);

    always_comb begin
        note = make_note(10'd0, 8'd1, 1'b1);
        case (fx_id)
            FX_SHOT: begin
                case (step)
                    STEP_W'(0): note = make_note(10'd500, 8'd2, 1'b0);
                    STEP_W'(1): note = make_note(10'd400, 8'd2, 1'b0);
                    default:    note = make_note(10'd300, 8'd1, 1'b1);
                endcase
            end
            FX_EXPLODE: begin
                case (step)
                    STEP_W'(0): note = make_note(10'd200, 8'd3, 1'b0);
                    STEP_W'(1): note = make_note(10'd0,   8'd3, 1'b0);
                    STEP_W'(2): note = make_note(10'd150, 8'd2, 1'b0);
                    default:    note = make_note(10'd100, 8'd4, 1'b1);
                endcase
            end
            FX_UFO: begin
                // Rising warble with no last flag: the step limit ends it.
                note = make_note(10'(16'd600 + 16'd20 * 16'(step)), 8'd1, 1'b0);
            end
            FX_PLAYER_HIT: begin
                case (step)
                    STEP_W'(0): note = make_note(10'd800, 8'd0, 1'b0);
                    default:    note = make_note(10'd700, 8'd1, 1'b1);
                endcase
            end
            default: note = make_note(10'd0, 8'd1, 1'b1);
        endcase
    end

endmodule

// File: rtl/sound_fx_sequencer.sv
// ---------------------------------------------------------------------------
// sound_fx_sequencer
// Plays sound effects as note sequences from sound_fx_rom, driving the
// prescaler divider and sound gate, holding each note for its duration
// and separating notes with a silent gap.
//   clk     in   system clock
//   resetN  in   asynchronous active-low reset
//   bus     slave side of sound_fx_sequencer_if
//           (fx_req/fx_id in; preScaleValue, enableSound, busy, fx_done,
//            cur_id out; all outputs registered)
// ---------------------------------------------------------------------------
module sound_fx_sequencer
    import sound_pkg::*;
#(
    parameter int CLKS_PER_MS = 50000,
    parameter int GAP_MS      = 1,
    parameter int MAX_STEPS   = 16
) (
    input  logic                 clk,
    input  logic                 resetN,
    sound_fx_sequencer_if.slave  bus
);

    localparam int STEP_W = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;
    localparam int CNT_W  = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_MS - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(MAX_STEPS - 1);
    localparam logic [DUR_W-1:0]  GAP_LEN   = DUR_W'(GAP_MS);

    fx_state_t           state;
    logic [STEP_W-1:0]   step;
    logic [CNT_W-1:0]    clk_cnt;
    logic [DUR_W-1:0]    ms_cnt;
    logic [DUR_W-1:0]    dur;
    logic                last_note;
    logic [PITCH_W-1:0]  pre_scale;
    logic                sound_on;
    logic                busy_q;
    logic                done_q;
    logic [FX_ID_W-1:0]  cur_id_q;

    fx_note_t            rom_note;
    logic                ms_tick;
    logic                note_end;
    logic                gap_end;
    logic                final_step;
    logic                accept;

    sound_fx_rom #(
        .STEP_W (STEP_W)
    ) u_rom (
        .fx_id (cur_id_q),
        .step  (step),
        .note  (rom_note)
    );

    assign ms_tick    = (clk_cnt == CNT_LAST);
    assign note_end   = ms_tick && ((ms_cnt + 8'd1) == dur);
    assign gap_end    = ms_tick && ((ms_cnt + 8'd1) == GAP_LEN);
    assign final_step = last_note || (step == STEP_LAST);

    // Idle accepts anything; while busy only an equal or higher id preempts.
    // This also covers the completion cycle, where a restart suppresses fx_done.
    assign accept = bus.fx_req && ((state == IDLE) || (bus.fx_id >= cur_id_q));

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= IDLE;
            step      <= '0;
            clk_cnt   <= '0;
            ms_cnt    <= '0;
            dur       <= '0;
            last_note <= 1'b0;
            pre_scale <= '0;
            sound_on  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cur_id_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                // Pitch is held until LOAD fetches the new first note.
                cur_id_q <= bus.fx_id;
                step     <= '0;
                clk_cnt  <= '0;
                ms_cnt   <= '0;
                sound_on <= 1'b0;
                busy_q   <= 1'b1;
                state    <= LOAD;
            end else begin
                case (state)
                    IDLE: begin
                    end
                    LOAD: begin
                        pre_scale <= rom_note.pitch;
                        sound_on  <= (rom_note.pitch != '0);
                        dur       <= (rom_note.dur_ms == '0) ? 8'd1 : rom_note.dur_ms;
                        last_note <= rom_note.last;
                        clk_cnt   <= '0;
                        ms_cnt    <= '0;
                        state     <= PLAY;
                    end
                    PLAY: begin
                        if (ms_tick) begin
                            clk_cnt <= '0;
                            ms_cnt  <= ms_cnt + 8'd1;
                        end else begin
                            clk_cnt <= clk_cnt + CNT_W'(1);
                        end
                        if (note_end) begin
                            sound_on <= 1'b0;
                            clk_cnt  <= '0;
                            ms_cnt   <= '0;
                            if (final_step) begin
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                                state  <= IDLE;
                            end else begin
                                step  <= step + STEP_W'(1);
                                state <= (GAP_MS > 0) ? GAP : LOAD;
                            end
                        end
                    end
                    GAP: begin
                        if (ms_tick) begin
                            clk_cnt <= '0;
                            ms_cnt  <= ms_cnt + 8'd1;
                        end else begin
                            clk_cnt <= clk_cnt + CNT_W'(1);
                        end
                        if (gap_end) begin
                            clk_cnt <= '0;
                            ms_cnt  <= '0;
                            state   <= LOAD;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.preScaleValue = pre_scale;
    assign bus.enableSound   = sound_on;
    assign bus.busy          = busy_q;
    assign bus.fx_done       = done_q;
    assign bus.cur_id        = cur_id_q;

endmodule

// File: tb/tb_sound_fx_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sound_fx_sequencer
// Self-checking bench for sound_fx_sequencer (CLKS_PER_MS=10, GAP_MS=1).
// Each accepted request expands the effect's note list into the expected
// per-cycle output trace; a monitor pops one entry per clock and compares.
// ---------------------------------------------------------------------------
module tb_sound_fx_sequencer;
    import sound_pkg::*;

    localparam int CLKS = 10;
    localparam int GAPM = 1;
    localparam int MAXS = 16;

    typedef struct packed {
        logic        busy;
        logic        en;
        logic [9:0]  psv;
        logic        done;
        logic [2:0]  id;
    } rec_t;

    logic clk;
    logic resetN;
    int   checks;
    int   errors;
    rec_t q[$];
    rec_t last_rec;

    sound_fx_sequencer_if bus_if();

    sound_fx_sequencer #(
        .CLKS_PER_MS (CLKS),
        .GAP_MS      (GAPM),
        .MAX_STEPS   (MAXS)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic rec_t mk(input bit b, input bit e, input logic [9:0] p,
                                input bit d, input logic [2:0] id);
        rec_t r;
        r.busy = b;
        r.en   = e;
        r.psv  = p;
        r.done = d;
        r.id   = id;
        return r;
    endfunction

    function automatic rec_t actRec();
        return mk(bus_if.busy, bus_if.enableSound, bus_if.preScaleValue,
                  bus_if.fx_done, bus_if.cur_id);
    endfunction

    // Effect note lists: pitch, duration in ms (0 plays as 1 ms), last flag.
    task automatic refNote(input logic [2:0] id, input int k,
                           output int pitch, output int dur, output bit last);
        pitch = 0; dur = 1; last = 1'b1;
        case (id)
            3'd1: begin
                pitch = (k == 0) ? 500 : (k == 1) ? 400 : 300;
                dur   = (k < 2) ? 2 : 1;
                last  = (k >= 2);
            end
            3'd2: begin
                case (k)
                    0: begin pitch = 200; dur = 3; last = 1'b0; end
                    1: begin pitch = 0;   dur = 3; last = 1'b0; end
                    2: begin pitch = 150; dur = 2; last = 1'b0; end
                    default: begin pitch = 100; dur = 4; last = 1'b1; end
                endcase
            end
            3'd3: begin pitch = 600 + 20 * k; dur = 1; last = 1'b0; end
            3'd4: begin
                if (k == 0) begin pitch = 800; dur = 0; last = 1'b0; end
                else        begin pitch = 700; dur = 1; last = 1'b1; end
            end
            default: begin pitch = 0; dur = 1; last = 1'b1; end
        endcase
    endtask

    // Expected outputs for every cycle from the accept edge to completion.
    task automatic buildTrace(input logic [2:0] id, input logic [9:0] prev);
        int p, d;
        bit l;
        logic [9:0] psv;
        psv = prev;
        q.delete();
        for (int k = 0; k < MAXS; k++) begin
            if (k > 0)
                for (int g = 0; g < GAPM * CLKS; g++) q.push_back(mk(1, 0, psv, 0, id));
            q.push_back(mk(1, 0, psv, 0, id));
            refNote(id, k, p, d, l);
            if (d == 0) d = 1;
            psv = 10'(p);
            for (int c = 0; c < d * CLKS; c++) q.push_back(mk(1, p != 0, psv, 0, id));
            if (l || k == MAXS - 1) begin
                q.push_back(mk(0, 0, psv, 1, id));
                break;
            end
        end
    endtask

    task automatic topUp();
        rec_t r;
        if (q.size() == 0) begin
            r = last_rec;
            r.done = 1'b0;
            q.push_back(r);
        end
    endtask

    task automatic checkOutput(input string name, input rec_t act, input rec_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s @%0t: actual busy=%0b en=%0b psv=%0d done=%0b id=%0d, expected busy=%0b en=%0b psv=%0d done=%0b id=%0d",
                     name, $time, act.busy, act.en, act.psv, act.done, act.id,
                     exp.busy, exp.en, exp.psv, exp.done, exp.id);
        end
    endtask

    task automatic driveNow(input bit req, input logic [2:0] id);
        topUp();
        bus_if.fx_req = req;
        bus_if.fx_id  = id;
        if (req && (!last_rec.busy || id >= last_rec.id))
            buildTrace(id, last_rec.psv);
    endtask

    task automatic applyStimulus(input bit req, input logic [2:0] id);
        @(negedge clk);
        driveNow(req, id);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b0, 3'd0);
    endtask

    task automatic drainIdle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(1'b0, 3'd0);
            if (!last_rec.busy && !last_rec.done && q.size() <= 1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++; errors++;
            $display("[TB] FAIL drain_timeout: actual still busy, required idle within 3000 cycles");
        end
    endtask

    // Stops on the negedge just before the expected completion edge.
    task automatic waitDoneEdge();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            topUp();
            bus_if.fx_req = 1'b0;
            if (q[0].done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++; errors++;
            $display("[TB] FAIL done_wait_timeout: actual no completion, required completion within 3000 cycles");
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (resetN) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("[TB] FAIL scoreboard_empty @%0t: actual no expected entry, required one per cycle", $time);
            end else begin
                rec_t e;
                e = q.pop_front();
                last_rec = e;
                checkOutput("cycle", actRec(), e);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual simulation still running, required finish before 500000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        last_rec = '0;
        q.delete();
        resetN = 1'b0;
        bus_if.fx_req = 1'b0;
        bus_if.fx_id  = 3'd0;

        #1;
        checkOutput("reset_state", actRec(), '0);
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        topUp();
        idleCycles(3);

        $display("[TB] shot sequence");
        applyStimulus(1'b1, FX_SHOT);
        drainIdle();
        idleCycles(3);

        $display("[TB] explode sequence with rest note");
        applyStimulus(1'b1, FX_EXPLODE);
        drainIdle();
        idleCycles(2);

        $display("[TB] preempt by higher id, lower id ignored");
        applyStimulus(1'b1, FX_SHOT);
        idleCycles(30);
        applyStimulus(1'b1, FX_EXPLODE);
        idleCycles(40);
        applyStimulus(1'b1, FX_SHOT);
        drainIdle();

        $display("[TB] request on completion cycle");
        applyStimulus(1'b1, FX_SHOT);
        waitDoneEdge();
        driveNow(1'b1, FX_UFO);
        drainIdle();

        $display("[TB] unused ids and zero-duration note");
        applyStimulus(1'b1, 3'd0);
        drainIdle();
        applyStimulus(1'b1, 3'd6);
        drainIdle();
        applyStimulus(1'b1, FX_PLAYER_HIT);
        drainIdle();

        $display("[TB] reset during playback");
        applyStimulus(1'b1, FX_EXPLODE);
        idleCycles(8);
        @(posedge clk);
        #3;
        resetN = 1'b0;
        q.delete();
        last_rec = '0;
        #1;
        checkOutput("async_reset", actRec(), '0);
        repeat (3) @(negedge clk);
        resetN = 1'b1;
        topUp();
        idleCycles(2);
        applyStimulus(1'b1, FX_SHOT);
        drainIdle();

        $display("[TB] random requests");
        for (int n = 0; n < 30; n++) begin
            applyStimulus(1'b1, 3'($urandom_range(0, 7)));
            idleCycles($urandom_range(0, 80));
        end
        drainIdle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
